// File: rtl/hdmi_meas_pkg.sv
// hdmi_meas_pkg: shared types and constants for the HDMI measurement blocks
//   meas_state_t  : measurement FSM states (IDLE, ARM, COUNT)
//   DEF_TIMEOUT   : default no-edge timeout in clk cycles
//   timeout_fits  : checks 2 <= timeout < 2^width for counter sizing
package hdmi_meas_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2
    } meas_state_t;

    localparam int unsigned DEF_TIMEOUT = 32'd1 << 24;

    function automatic logic timeout_fits(input int unsigned t, input int w);
        return (t >= 32'd2) && ((w >= 32) || (t < (32'd1 << w)));
    endfunction

endpackage

// File: rtl/evt_edge_detect.sv
// evt_edge_detect: registers an event input and flags its rising edges
//   clk      : clock
//   rst      : asynchronous active-high reset
//   i_evt    : event input (asynchronous when PERIOD_METER_SYNC_EN is defined)
//   o_edge   : one-cycle pulse, evt_q & ~evt_p
// Build option: PERIOD_METER_SYNC_EN adds a 2-flop synchronizer ahead of evt_q.
module evt_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_evt,
    output logic o_edge
);

    logic w_evt_s;
    logic r_evt_q;
    logic r_evt_p;

`ifdef PERIOD_METER_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_evt;
            r_sync2 <= r_sync1;
        end
    end

    assign w_evt_s = r_sync2;
`else
    assign w_evt_s = i_evt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_evt_q <= 1'b0;
            r_evt_p <= 1'b0;
        end else begin
            r_evt_q <= w_evt_s;
            r_evt_p <= r_evt_q;
        end
    end

    assign o_edge = r_evt_q & ~r_evt_p;

endmodule

// File: rtl/period_meter.sv
// period_meter: measures clk cycles between rising edges of evt_in
//   clk, rst       : clock, asynchronous active-high reset
//   meas_ena       : level-sensitive measurement enable
//   evt_in         : event input whose rising edges are measured
//   period_ready   : consumer accepts the held result
//   ovr_clr        : synchronous clear of overrun
//   period_valid   : a result is held on the output
//   period_data    : measured period (TIMEOUT for a timeout result)
//   period_timeout : held result is a timeout
//   overrun        : sticky, a result was dropped
// Build option: PERIOD_METER_SYNC_EN (see evt_edge_detect).
module period_meter
    import hdmi_meas_pkg::*;
#(
    parameter int          CNT_W   = 32,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             meas_ena,
    input  logic             evt_in,
    input  logic             period_ready,
    input  logic             ovr_clr,
    output logic             period_valid,
    output logic [CNT_W-1:0] period_data,
    output logic             period_timeout,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    if (!timeout_fits(TIMEOUT, CNT_W)) begin : g_bad_cfg
        $error("period_meter: TIMEOUT must satisfy 2 <= TIMEOUT < 2^CNT_W");
    end

    meas_state_t      r_state;
    meas_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_edge;
    logic             w_at_tmo;
    logic             w_emit;
    logic             w_emit_to;

    // Emitted result is staged one cycle before the output register
    logic             r_res_vld;
    logic             r_res_to;
    logic [CNT_W-1:0] r_res_data;

    logic             r_valid;
    logic             r_to;
    logic [CNT_W-1:0] r_data;
    logic             r_ovr;
    logic             w_load;
    logic             w_drop;

    evt_edge_detect u_edge (
        .clk    (clk),
        .rst    (rst),
        .i_evt  (evt_in),
        .o_edge (w_edge)
    );

    assign w_at_tmo = (r_cnt == TMO);

    // An edge coinciding with cnt == TIMEOUT takes priority over the timeout
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_emit      = 1'b0;
        w_emit_to   = 1'b0;
        if (!meas_ena) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = ARM;
                    w_cnt_nxt   = '0;
                end
                ARM: begin
                    if (w_edge) begin
                        w_state_nxt = COUNT;
                        w_cnt_nxt   = CNT_W'(1);
                    end else if (w_at_tmo) begin
                        w_emit    = 1'b1;
                        w_emit_to = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                COUNT: begin
                    if (w_edge) begin
                        w_emit    = 1'b1;
                        w_cnt_nxt = CNT_W'(1);
                    end else if (w_at_tmo) begin
                        w_emit      = 1'b1;
                        w_emit_to   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ARM;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_res_vld  <= 1'b0;
            r_res_to   <= 1'b0;
            r_res_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_res_vld  <= w_emit;
            r_res_to   <= w_emit_to;
            r_res_data <= r_cnt;
        end
    end

    assign w_load = r_res_vld && (!r_valid || period_ready);
    assign w_drop = r_res_vld && !w_load;

    // A drop in the same cycle as ovr_clr leaves overrun set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_to    <= 1'b0;
            r_data  <= '0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid <= 1'b1;
                r_to    <= r_res_to;
                r_data  <= r_res_data;
            end else if (period_ready) begin
                r_valid <= 1'b0;
            end
            r_ovr <= w_drop | (r_ovr & ~ovr_clr);
        end
    end

    assign period_valid   = r_valid;
    assign period_data    = r_data;
    assign period_timeout = r_to;
    assign overrun        = r_ovr;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed self-checking bench for period_meter
module tb_period_meter;
    import hdmi_meas_pkg::*;

    // Negedges from evt_in drive to observed period_valid
`ifdef PERIOD_METER_SYNC_EN
    localparam int L = 5;
`else
    localparam int L = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        meas_ena = 1'b0;
    logic        evt_in = 1'b0;
    logic        period_ready = 1'b0;
    logic        ovr_clr = 1'b0;

    logic        a_valid, a_to, a_ovr;
    logic [31:0] a_data;
    logic        b_valid, b_to, b_ovr;
    logic [15:0] b_data;
    logic        c_valid, c_to, c_ovr;
    logic [7:0]  c_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    period_meter #(.CNT_W(32), .TIMEOUT(1000)) u_a (
        .clk(clk), .rst(rst), .meas_ena(meas_ena), .evt_in(evt_in),
        .period_ready(period_ready), .ovr_clr(ovr_clr),
        .period_valid(a_valid), .period_data(a_data),
        .period_timeout(a_to), .overrun(a_ovr)
    );

    period_meter #(.CNT_W(16), .TIMEOUT(50)) u_b (
        .clk(clk), .rst(rst), .meas_ena(meas_ena), .evt_in(evt_in),
        .period_ready(period_ready), .ovr_clr(ovr_clr),
        .period_valid(b_valid), .period_data(b_data),
        .period_timeout(b_to), .overrun(b_ovr)
    );

    period_meter #(.CNT_W(8), .TIMEOUT(20)) u_c (
        .clk(clk), .rst(rst), .meas_ena(meas_ena), .evt_in(evt_in),
        .period_ready(period_ready), .ovr_clr(ovr_clr),
        .period_valid(c_valid), .period_data(c_data),
        .period_timeout(c_to), .overrun(c_ovr)
    );

    task automatic do_reset();
        rst = 1'b1;
        meas_ena = 1'b0;
        evt_in = 1'b0;
        period_ready = 1'b0;
        ovr_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", a_valid); end
        checks++;
        if (a_data !== 32'd0) begin errors++; $display("FAIL reset_data got %0d expected 0", a_data); end
        checks++;
        if (a_to !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b expected 0", a_to); end
        checks++;
        if (a_ovr !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b expected 0", a_ovr); end
        checks++;
        if ({b_valid, c_valid, b_ovr, c_ovr} !== 4'b0) begin
            errors++; $display("FAIL reset_other got %b expected 0000", {b_valid, c_valid, b_ovr, c_ovr});
        end
    endtask

    task automatic test_periodic();
        int n = 0;
        int first = -1;
        do_reset();
        meas_ena = 1'b1;
        period_ready = 1'b1;
        for (int k = 0; k < 450; k++) begin
            @(negedge clk);
            if (a_valid) begin
                if (first < 0) first = k;
                n++;
                checks++;
                if (a_data !== 32'd100 || a_to !== 1'b0) begin
                    errors++; $display("FAIL periodic_data k=%0d got %0d/%b expected 100/0", k, a_data, a_to);
                end
            end
            evt_in = (k % 100 == 10);
        end
        checks++;
        if (n != 4) begin errors++; $display("FAIL periodic_count got %0d expected 4", n); end
        checks++;
        if (first != 110 + L) begin errors++; $display("FAIL periodic_latency got %0d expected %0d", first, 110 + L); end
    endtask

    task automatic test_no_edges();
        int n = 0;
        int first = -1;
        int last = -1;
        do_reset();
        meas_ena = 1'b1;
        period_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (b_valid) begin
                n++;
                checks++;
                if (b_data !== 16'd50 || b_to !== 1'b1) begin
                    errors++; $display("FAIL timeout_data k=%0d got %0d/%b expected 50/1", k, b_data, b_to);
                end
                if (first < 0) first = k;
                else begin
                    checks++;
                    if (k - last != 51) begin errors++; $display("FAIL timeout_gap got %0d expected 51", k - last); end
                end
                last = k;
            end
        end
        checks++;
        if (n != 3) begin errors++; $display("FAIL timeout_count got %0d expected 3", n); end
        checks++;
        if (first != 52) begin errors++; $display("FAIL timeout_first got %0d expected 52", first); end
    endtask

    task automatic test_backpressure();
        int first = -1;
        int unstable = 0;
        int n = 0;
        do_reset();
        meas_ena = 1'b1;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (k < 40) begin
                if (first < 0 && a_valid) first = k;
                if (first >= 0 && (a_valid !== 1'b1 || a_data !== 32'd10)) unstable++;
            end
            if (k == 39) begin
                checks++;
                if (first != 12 + L) begin errors++; $display("FAIL bp_first got %0d expected %0d", first, 12 + L); end
                checks++;
                if (unstable != 0) begin errors++; $display("FAIL bp_stable got %0d unstable cycles expected 0", unstable); end
                checks++;
                if (a_valid !== 1'b1 || a_data !== 32'd10) begin
                    errors++; $display("FAIL bp_held got %b/%0d expected 1/10", a_valid, a_data);
                end
                checks++;
                if (a_ovr !== 1'b1) begin errors++; $display("FAIL bp_overrun got %b expected 1", a_ovr); end
            end
            if (k == 41) begin
                checks++;
                if (a_valid !== 1'b0) begin errors++; $display("FAIL bp_accept got %b expected 0", a_valid); end
            end
            if (k == 43) begin
                checks++;
                if (a_ovr !== 1'b0) begin errors++; $display("FAIL bp_ovr_clr got %b expected 0", a_ovr); end
            end
            if (k > 41 && a_valid) begin
                n++;
                checks++;
                if (a_data !== 32'd10) begin errors++; $display("FAIL bp_resume got %0d expected 10", a_data); end
            end
            evt_in = (k % 10 == 2);
            period_ready = (k >= 40);
            ovr_clr = (k == 41);
        end
        ovr_clr = 1'b0;
        checks++;
        if (n != 3) begin errors++; $display("FAIL bp_resume_count got %0d expected 3", n); end
    endtask

    task automatic test_timeout_boundary();
        int n = 0;
        do_reset();
        meas_ena = 1'b1;
        period_ready = 1'b1;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (c_valid) begin
                n++;
                checks++;
                if (c_data !== 8'd20 || c_to !== 1'b0) begin
                    errors++; $display("FAIL boundary_data k=%0d got %0d/%b expected 20/0", k, c_data, c_to);
                end
            end
            evt_in = (k % 20 == 3);
        end
        checks++;
        if (n != 5) begin errors++; $display("FAIL boundary_count got %0d expected 5", n); end
        checks++;
        if (u_c.r_state !== COUNT) begin errors++; $display("FAIL boundary_state got %0d expected %0d", u_c.r_state, COUNT); end
    endtask

    task automatic test_disable();
        int n = 0;
        do_reset();
        meas_ena = 1'b1;
        period_ready = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (a_valid) begin
                n++;
                checks++;
                if (k != 60 + L || a_data !== 32'd30) begin
                    errors++; $display("FAIL disable_result k=%0d got %0d expected k=%0d data 30", k, a_data, 60 + L);
                end
            end
            evt_in = (k == 5 || k == 30 || k == 60);
            meas_ena = !(k == 10 || k == 11);
        end
        checks++;
        if (n != 1) begin errors++; $display("FAIL disable_count got %0d expected 1", n); end
    endtask

    task automatic test_rst_mid();
        int n = 0;
        do_reset();
        meas_ena = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 39) begin
                checks++;
                if (a_valid !== 1'b1 || a_data !== 32'd20 || a_ovr !== 1'b1) begin
                    errors++; $display("FAIL rst_pre got %b/%0d/%b expected 1/20/1", a_valid, a_data, a_ovr);
                end
            end
            evt_in = (k == 5 || k == 25 || k == 31);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a_valid, a_to, a_ovr} !== 3'b000 || a_data !== 32'd0) begin
            errors++; $display("FAIL rst_async got %b%b%b/%0d expected 000/0", a_valid, a_to, a_ovr, a_data);
        end
        rst = 1'b0;
        period_ready = 1'b1;
        for (int k = 40; k < 90; k++) begin
            @(negedge clk);
            if (a_valid) begin
                n++;
                checks++;
                if (k != 70 + L || a_data !== 32'd20) begin
                    errors++; $display("FAIL rst_after k=%0d got %0d expected k=%0d data 20", k, a_data, 70 + L);
                end
            end
            evt_in = (k == 50 || k == 70);
        end
        checks++;
        if (n != 1) begin errors++; $display("FAIL rst_after_count got %0d expected 1", n); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        do_reset();
        meas_ena = 1'b1;
        period_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (a_valid) begin
                n++;
                checks++;
                if (a_data !== 32'd2 || a_to !== 1'b0) begin
                    errors++; $display("FAIL b2b_data k=%0d got %0d/%b expected 2/0", k, a_data, a_to);
                end
            end
            evt_in = (k < 30) && (k % 2 == 1);
        end
        checks++;
        if (n != 14) begin errors++; $display("FAIL b2b_count got %0d expected 14", n); end
        checks++;
        if (a_ovr !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b expected 0", a_ovr); end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_no_edges();
        test_backpressure();
        test_timeout_boundary();
        test_disable();
        test_rst_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the interval, in `clk` cycles, between consecutive rising edges of an event input such as vsync, hsync or a divided pixel clock, and reports each measurement through a valid/ready output. It is the measuring counterpart of the timer block: the timer generates a pulse after a fixed count, and this block counts the cycles between pulses it receives. The HDMI video-detect logic uses it to check link timing and to flag a lost input.

## Interface
- `CNT_W`, 32: width of the cycle counter and of `period_data`.
- `TIMEOUT`, 1 << 24: cycles without an edge before a timeout result is produced. Must satisfy 2 ≤ TIMEOUT < 2^CNT_W.
- `clk` input 1: single clock; every flop in the block runs on it.
- `rst` input 1: asynchronous, active-high reset.
- `meas_ena` input 1: measurement enable, level-sensitive.
- `evt_in` input 1: event input. Rising edges are measured.
- `period_ready` input 1: consumer accepts `period_data`.
- `ovr_clr` input 1: synchronous clear of `overrun`.
- `period_valid` output 1: a result is held on the output.
- `period_data` output CNT_W: the measured period in cycles.
- `period_timeout` output 1: the held result is a timeout; `period_data` = TIMEOUT.
- `overrun` output 1: sticky; set when a result was dropped.

## Operation
- Event path: `evt_q` is `evt_in` registered once. `evt_p` is `evt_q` delayed by one cycle. The edge signal `edge` = `evt_q & ~evt_p`.
- IDLE:
  - `cnt` = 0.
  - `meas_ena` = 1 → ARM.
- ARM:
  - `cnt` increments every cycle.
  - `edge` → `cnt` ← 1, go to COUNT.
  - `cnt` == TIMEOUT with no `edge` → emit a timeout result, `cnt` ← 0, stay in ARM.
- COUNT:
  - No `edge` → `cnt` ← `cnt` + 1.
  - `edge` → emit a result equal to `cnt`, `cnt` ← 1, stay in COUNT. Measurement is continuous: each edge ends one period and starts the next.
  - `cnt` == TIMEOUT with no `edge` → emit a timeout result, `cnt` ← 0, go to ARM.
- `edge` in the same cycle as `cnt` == TIMEOUT: the edge wins. A normal result with value TIMEOUT is emitted, `period_timeout` = 0.
- `meas_ena` = 0 in any state:
  - Next state is IDLE and `cnt` ← 0.
  - Any measurement in progress is discarded without emitting a result.
  - A result already held on the output stays until accepted.
- Output register:
  - An emitted result loads `period_data` and `period_timeout`, and sets `period_valid`, when `!period_valid || period_ready`.
  - Otherwise the result is dropped and `overrun` ← 1.
- Handshake:
  - `period_valid && period_ready` completes a transfer.
  - `period_valid` falls after the transfer unless a new result loads in the same cycle.
  - `period_data` is stable while `period_valid` = 1 and `period_ready` = 0.
- `overrun`:
  - Cleared by `ovr_clr`.
  - If `ovr_clr` and a drop occur in the same cycle, the set wins.
- Arithmetic: `cnt` never exceeds TIMEOUT, so it cannot wrap. The minimum measurable period is 2, because consecutive rising edges need at least one low cycle between them.

## Timing
- Reset values: state = IDLE, `cnt` = 0, `evt_q` = `evt_p` = 0, and all sync flops = 0. Every output is 0: `period_valid`, `period_data`, `period_timeout`, `overrun`.
- Latency: `period_valid` rises 2 `clk` edges after the edge at which `evt_in` is first sampled high. PERIOD_METER_SYNC_EN adds 2 more.
- Throughput: one result per cycle can be accepted when `period_ready` is tied high.
- `rst` asserted mid-measurement: immediate return to reset values. The first period after release requires two fresh edges.

## Configuration
- `PERIOD_METER_SYNC_EN` defined:
  - Inserts a 2-flop synchronizer ahead of `evt_q`, so `evt_in` may be asynchronous to `clk`.
  - Latency +2 cycles. Measured periods are unchanged.
- Not defined: `evt_in` must be synchronous to `clk`.

## Structure
- Shared package `hdmi_meas_pkg`:
  - The state enum `meas_state_t` (IDLE, ARM, COUNT).
  - The default TIMEOUT constant.
  - A width helper for CNT_W checks.
- Sub-module `evt_edge_detect`:
  - Contains the optional synchronizer, `evt_q`/`evt_p` and the `edge` output.
  - Instantiated once.
  - Reused by other detect blocks.

## Test plan
- Periodic edges: TIMEOUT = 1000; `meas_ena` = 1; rising edges of `evt_in` every 100 cycles; `period_ready` = 1 → first result after the second edge. Every result is `period_data` = 100 with `period_timeout` = 0.
- No edges: TIMEOUT = 50; `meas_ena` = 1; `evt_in` held at 0 → a timeout result (`period_data` = 50, `period_timeout` = 1) every 51 cycles.
- Backpressure: edge period 10; `period_ready` = 0 for 35 cycles → the first result is held stable at 10 and `overrun` = 1. After `period_ready` rises, `ovr_clr` returns `overrun` to 0.
- Edge on the timeout boundary: TIMEOUT = 20, edge period exactly 20 → `period_data` = 20 with `period_timeout` = 0, and the state remains COUNT.
- Disable or reset mid-period: drop `meas_ena` 5 cycles after an edge, then re-enable → no result is emitted until two new edges. Repeat with a `rst` pulse → all outputs go to 0 asynchronously.
- Synchronizer build: compile with PERIOD_METER_SYNC_EN and drive an edge period of 64 → `period_data` = 64 and latency is 4 cycles.
